mmio_axil_master: RTL

Sequencer between the core's load/store MMIO request and the AXI-Lite bus that serves the 0x30xx_xxxx peripheral window (GPIO and friends). The block accepts one request at a time and holds every AXI valid until its handshake completes. It accepts AW and W independently, waits for B or R, and returns a single-cycle response pulse carrying read data and an error flag. A per-transaction timeout keeps the pipeline from hanging forever on an unresponsive slave.

---
 rtl/mmio_axil_master_if.sv | 34 +++
 rtl/mmio_axil_master.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mmio_axil_master_if.sv
// AXI-Lite bus bundle for the MMIO master; the master modport drives addresses, data and readies,
// and the slave modport is the peripheral side.
interface mmio_axil_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mmio_axil_master.sv
// Single-outstanding sequencer from the core's MMIO load/store port onto an AXI-Lite master,
// with a per-transaction bus-phase timeout and a one-cycle response pulse.
module mmio_axil_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req_valid_i,
  input  logic                req_write_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                req_ready_o,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  mmio_axil_master_if.master  m_axi
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit   TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic                awvalid_reg, awvalid_next;
  logic                wvalid_reg, wvalid_next;
  logic                arvalid_reg, arvalid_next;
  logic                bready_reg, rready_reg;
  logic                req_ready_reg, rsp_valid_reg;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                rsp_err_reg, rsp_err_next;
  logic                timeout_hit;
  logic                b_err, r_err;

  // SLVERR (2'b10) and DECERR (2'b11) are errors; OKAY and EXOKAY are not.
  assign b_err = (m_axi.bresp == 2'b10) || (m_axi.bresp == 2'b11);
  assign r_err = (m_axi.rresp == 2'b10) || (m_axi.rresp == 2'b11);
  assign timeout_hit = TO_EN && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    arvalid_next   = arvalid_reg;
    cnt_next       = cnt_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid_i) begin
          addr_next  = req_addr_i;
          wdata_next = req_wdata_i;
          wstrb_next = req_wstrb_i;
          cnt_next   = '0;
          if (req_write_i) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = WR_AW_W;
          end else begin
            arvalid_next = 1'b1;
            state_next   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        awvalid_next = awvalid_reg & ~m_axi.awready;
        wvalid_next  = wvalid_reg & ~m_axi.wready;
        if (!awvalid_next && !wvalid_next) state_next = WR_B;
      end
      RD_AR: begin
        if (m_axi.arready) begin
          arvalid_next = 1'b0;
          state_next   = RD_R;
        end
      end
      WR_B: begin
        if (m_axi.bvalid) begin
          state_next     = RESP;
          rsp_err_next   = b_err;
          rsp_rdata_next = '0;
        end
      end
      RD_R: begin
        if (m_axi.rvalid) begin
          state_next     = RESP;
          rsp_err_next   = r_err;
          rsp_rdata_next = r_err ? '0 : m_axi.rdata;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A B/R beat accepted in the limit cycle still completes normally; otherwise abort.
    if (state_reg inside {WR_AW_W, WR_B, RD_AR, RD_R}) begin
      cnt_next = cnt_reg + 1'b1;
      if (timeout_hit && state_next != RESP) begin
        state_next     = RESP;
        awvalid_next   = 1'b0;
        wvalid_next    = 1'b0;
        arvalid_next   = 1'b0;
        rsp_err_next   = 1'b1;
        rsp_rdata_next = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      bready_reg    <= 1'b0;
      rready_reg    <= 1'b0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      cnt_reg       <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      arvalid_reg   <= arvalid_next;
      bready_reg    <= (state_next == WR_B);
      rready_reg    <= (state_next == RD_R);
      req_ready_reg <= (state_next == IDLE);
      rsp_valid_reg <= (state_next == RESP);
      cnt_reg       <= cnt_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  assign req_ready_o   = req_ready_reg;
  assign rsp_valid_o   = rsp_valid_reg;
  assign rsp_rdata_o   = rsp_rdata_reg;
  assign rsp_err_o     = rsp_err_reg;
  assign m_axi.awaddr  = addr_reg;
  assign m_axi.awvalid = awvalid_reg;
  assign m_axi.wdata   = wdata_reg;
  assign m_axi.wstrb   = wstrb_reg;
  assign m_axi.wvalid  = wvalid_reg;
  assign m_axi.bready  = bready_reg;
  assign m_axi.araddr  = addr_reg;
  assign m_axi.arvalid = arvalid_reg;
  assign m_axi.rready  = rready_reg;

endmodule
